multi_channel_counter: RTL and testbench
========================================

# multi_channel_counter

Parametrised bank of CHANNELS independent modulo-MODULO counters, each with its own enable, up/down direction, parallel load and one-shot mode. Every count value leaves the block tagged with its channel index in the LSBs, so downstream display and mux logic can tell the channels apart on a shared bus. It replaces fixed-width, fixed-two-channel free-running counters in the lab datapath, and adds wrap and done status per channel.

## Interface
Parameters:
- WIDTH, 6: count register width per channel.
- CHANNELS, 2: number of counter channels (1..16).
- MODULO, 64: count range is 0..MODULO-1. Legal range is 2..2^WIDTH; elaboration fails otherwise.
- ID_W, max(1, $clog2(CHANNELS)): tag width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of all channels.
- en  in  CHANNELS  per-channel count enable.
- up  in  CHANNELS  per-channel direction: 1 counts up, 0 counts down.
- oneshot  in  CHANNELS  per-channel mode: 1 stops at the terminal value, 0 wraps.
- load  in  CHANNELS  per-channel parallel load strobe.
- load_val  in  CHANNELS*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
- q  out  CHANNELS*(WIDTH+ID_W)  tagged counts; channel i field is {count_i, i[ID_W-1:0]}.
- wrap  out  CHANNELS  one-cycle pulse after a channel wraps.
- done  out  CHANNELS  sticky flag set when a one-shot channel reaches its terminal value.

## Operation
- Per-channel priority on each edge: clr > load > en > hold.
- clr: count=0, wrap=0, done=0 on all channels.
- Load:
  - Sets count=load_val, or count=MODULO-1 when load_val≥MODULO.
  - Clears done and sets wrap=0.
  - Load takes effect regardless of en.
- en=1 with up=1:
  - count<MODULO-1 gives count+1.
  - count=MODULO-1 with oneshot=0 gives count=0 and wrap=1.
  - count=MODULO-1 with oneshot=1 holds the count and sets done=1.
- en=1 with up=0:
  - count>0 gives count-1.
  - count=0 with oneshot=0 gives count=MODULO-1 and wrap=1.
  - count=0 with oneshot=1 holds the count and sets done=1.
- Terminal value is MODULO-1 when counting up and 0 when counting down.
- Once done=1, the channel holds its count even with en=1, until load or clr.
- A direction change while done=1 does not release the channel.
- wrap is registered. It is high for exactly the one cycle following the wrapping edge, and low on every other cycle, including hold cycles.
- Arithmetic is WIDTH bits. The count never leaves 0..MODULO-1, so no overflow can occur inside the register.
- The tag LSBs are constant per channel: channel i always carries i in its low ID_W bits. CHANNELS=1 gives a 1-bit tag of 0.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- Reset asserted (reset=0), asynchronously:
  - All counts are 0 and wrap=0, done=0.
  - q therefore equals the tag pattern only, e.g. defaults give q[6:0]=7'b0000000 and q[13:7]=7'b0000001.
- Reset release is synchronous to the next rising edge. The first count can happen on the first edge with reset=1.
- Latency: one clock from en/load/clr to updated q, wrap and done. There are no combinational paths from inputs to outputs.
- Reset asserted mid-count clears the count immediately without waiting for clk. A pending wrap pulse is killed.
- load and a terminal condition on the same edge: load wins, no wrap, done cleared.
- clr and load on the same edge: clr wins.

## Test plan
- Reset/tag (defaults):
  - Hold reset=0, check q = {7'b0000001, 7'b0000000}.
  - Release reset with en=2'b11 and up=2'b11. After 5 edges, channel 0 field = {6'd5, 1'b0} and channel 1 field = {6'd5, 1'b1}.
- Up wrap, MODULO=10, WIDTH=4:
  - From count 0 with en=1, after 9 edges count=9 and wrap=0.
  - The 10th edge gives count=0 with wrap=1 for one cycle.
  - The 11th edge gives count=1 and wrap=0.
- Down one-shot:
  - Load 3 with oneshot=1, up=0, en=1.
  - Expect counts 2, 1, 0, then done=1 with count held at 0 for 4 more edges.
  - Then load 7: done=0 and count=7.
- Load clamp and priority, MODULO=10:
  - load_val=15 gives count=9.
  - clr=1 together with load=1 and load_val=5 gives count=0.
  - load=1 with en=0 still loads.
- Async reset mid-operation:
  - Assert reset=0 half a cycle after a wrapping edge. q returns to tags only and wrap drops at once, before the next clk edge.
- Channel independence, CHANNELS=4:
  - Set en=4'b0101 and up=4'b0001 for 3 edges from count 2 on all channels.
  - Expect ch0=5, ch1=2, ch2=63, ch3=2, with tags 0, 1, 2, 3 in ID_W=2 LSBs.

Source files
------------

// File: rtl/multi_channel_counter.sv
// multi_channel_counter: bank of independent modulo counters with load, one-shot mode,
// wrap/done status and channel-index-tagged outputs for a shared bus.
module multi_channel_counter #(
  parameter int WIDTH = 6,
  parameter int CHANNELS = 2,
  parameter int MODULO = 64,
  localparam int ID_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr,
  input  logic [CHANNELS-1:0]               en,
  input  logic [CHANNELS-1:0]               up,
  input  logic [CHANNELS-1:0]               oneshot,
  input  logic [CHANNELS-1:0]               load,
  input  logic [CHANNELS*WIDTH-1:0]         load_val,
  output logic [CHANNELS*(WIDTH+ID_W)-1:0]  q,
  output logic [CHANNELS-1:0]               wrap,
  output logic [CHANNELS-1:0]               done
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULO);
  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("multi_channel_counter: MODULO must be in 2..2**WIDTH");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("multi_channel_counter: CHANNELS must be in 1..16");
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nx;
    logic [WIDTH-1:0] w_lv;
    logic             r_wrap;
    logic             r_done;
    logic             w_term;
    logic             w_adv;
    always_comb begin
      w_lv = load_val[i*WIDTH +: WIDTH];
      w_term = up[i] ? (r_cnt == TOP) : (r_cnt == '0);
      w_adv = en[i] && !r_done;
      w_cnt_nx = clr ? '0
        : load[i] ? (({1'b0, w_lv} >= MOD_X) ? TOP : w_lv)
        : !w_adv ? r_cnt
        : !w_term ? (up[i] ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1))
        : oneshot[i] ? r_cnt
        : (up[i] ? '0 : TOP);
    end
    // clr and load both override any terminal event on the same edge
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r_cnt  <= '0;
        r_wrap <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nx;
        r_wrap <= !clr && !load[i] && w_adv && w_term && !oneshot[i];
        r_done <= !clr && !load[i] && (r_done || (w_adv && w_term && oneshot[i]));
      end
    assign q[i*(WIDTH+ID_W) +: WIDTH+ID_W] = {r_cnt, ID_W'(i)};
    assign wrap[i] = r_wrap;
    assign done[i] = r_done;
  end
endmodule

// File: tb/tb_multi_channel_counter.sv
// tb_multi_channel_counter: three configurations driven from shared stimulus and
// checked each cycle against a behavioural per-channel model.
module tb_multi_channel_counter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic [3:0] en = '0, up = '0, os = '0, ld = '0;
  logic [5:0] lv [4];
  logic [13:0] q0;
  logic [9:0]  q1;
  logic [31:0] q2;
  logic [1:0]  wrap0, done0, wrap1, done1;
  logic [3:0]  wrap2, done2;
  int total = 0;
  int bad = 0;
  int mods [3] = '{64, 10, 64};
  int chs  [3] = '{2, 2, 4};
  int ws   [3] = '{6, 4, 6};
  int idw  [3] = '{1, 1, 2};
  int cnt  [3][4];
  bit dn   [3][4];
  bit wr   [3][4];

  always #5 clk = ~clk;

  multi_channel_counter u0 (
    .clk(clk), .reset(reset), .clr(clr), .en(en[1:0]), .up(up[1:0]), .oneshot(os[1:0]),
    .load(ld[1:0]), .load_val({lv[1], lv[0]}), .q(q0), .wrap(wrap0), .done(done0));
  multi_channel_counter #(.WIDTH(4), .CHANNELS(2), .MODULO(10)) u1 (
    .clk(clk), .reset(reset), .clr(clr), .en(en[1:0]), .up(up[1:0]), .oneshot(os[1:0]),
    .load(ld[1:0]), .load_val({lv[1][3:0], lv[0][3:0]}), .q(q1), .wrap(wrap1), .done(done1));
  multi_channel_counter #(.WIDTH(6), .CHANNELS(4), .MODULO(64)) u2 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .up(up), .oneshot(os),
    .load(ld), .load_val({lv[3], lv[2], lv[1], lv[0]}), .q(q2), .wrap(wrap2), .done(done2));

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic int get_q(input int k, input int c);
    case (k)
      0: return int'(q0[c*7 +: 7]);
      1: return int'(q1[c*5 +: 5]);
      default: return int'(q2[c*8 +: 8]);
    endcase
  endfunction

  function automatic int get_w(input int k, input int c);
    case (k)
      0: return int'(wrap0[c]);
      1: return int'(wrap1[c]);
      default: return int'(wrap2[c]);
    endcase
  endfunction

  function automatic int get_d(input int k, input int c);
    case (k)
      0: return int'(done0[c]);
      1: return int'(done1[c]);
      default: return int'(done2[c]);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        cnt[k][c] = 0;
        dn[k][c] = 0;
        wr[k][c] = 0;
      end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < chs[k]; c++) begin
        int v;
        wr[k][c] = 0;
        if (clr) begin
          cnt[k][c] = 0;
          dn[k][c] = 0;
        end else if (ld[c]) begin
          v = int'(lv[c]) % (1 << ws[k]);
          cnt[k][c] = (v >= mods[k]) ? mods[k] - 1 : v;
          dn[k][c] = 0;
        end else if (en[c] && !dn[k][c]) begin
          if (up[c] && cnt[k][c] < mods[k] - 1) cnt[k][c]++;
          else if (!up[c] && cnt[k][c] > 0) cnt[k][c]--;
          else if (os[c]) dn[k][c] = 1;
          else begin
            cnt[k][c] = up[c] ? 0 : mods[k] - 1;
            wr[k][c] = 1;
          end
        end
      end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < chs[k]; c++) begin
        chk($sformatf("q[%0d][%0d]", k, c), get_q(k, c), cnt[k][c] * (1 << idw[k]) + c);
        chk($sformatf("wrap[%0d][%0d]", k, c), get_w(k, c), int'(wr[k][c]));
        chk($sformatf("done[%0d][%0d]", k, c), get_d(k, c), int'(dn[k][c]));
      end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset) model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic set_lv(input int v);
    for (int c = 0; c < 4; c++) lv[c] = 6'(v);
  endtask

  initial begin
    set_lv(0);
    model_reset();
    #2;
    check_all();
    chk("reset_q0", int'(q0), 14'b0000001_0000000);
    chk("reset_q2", int'(q2), 32'h03020100);
    @(negedge clk);
    reset = 1'b1;
    en = 4'b1111;
    up = 4'b1111;
    step(5);
    chk("tag_ch0", int'(q0[6:0]), {6'd5, 1'b0});
    chk("tag_ch1", int'(q0[13:7]), {6'd5, 1'b1});
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(9);
    chk("m10_cnt9", int'(q1[4:1]), 9);
    chk("m10_nowrap", int'(wrap1[0]), 0);
    step(1);
    chk("m10_cnt0", int'(q1[4:1]), 0);
    chk("m10_wrap", int'(wrap1[0]), 1);
    step(1);
    chk("m10_cnt1", int'(q1[4:1]), 1);
    chk("m10_wrapoff", int'(wrap1[0]), 0);
    set_lv(3);
    ld = 4'b1111;
    os = 4'b1111;
    up = 4'b0000;
    step(1);
    ld = 4'b0000;
    step(3);
    chk("os_cnt0", int'(q1[4:1]), 0);
    chk("os_notdone", int'(done1[0]), 0);
    step(1);
    chk("os_done", int'(done1[0]), 1);
    step(3);
    chk("os_hold", int'(q1[4:1]), 0);
    up = 4'b1111;
    step(1);
    chk("os_dirhold", int'(q1[4:1]), 0);
    set_lv(7);
    ld = 4'b1111;
    step(1);
    chk("os_reload", int'(q1[4:1]), 7);
    chk("os_doneclr", int'(done1[0]), 0);
    os = 4'b0000;
    set_lv(15);
    step(1);
    chk("clamp", int'(q1[4:1]), 9);
    set_lv(5);
    clr = 1'b1;
    step(1);
    chk("clr_wins", int'(q1[4:1]), 0);
    clr = 1'b0;
    en = 4'b0000;
    step(1);
    chk("load_no_en", int'(q1[4:1]), 5);
    set_lv(9);
    en = 4'b1111;
    step(1);
    ld = 4'b0000;
    step(1);
    chk("pre_rst_wrap", int'(wrap1[0]), 1);
    #4;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_wrap", int'(wrap1), 0);
    chk("async_q1", int'(q1), 10'b00001_00000);
    @(negedge clk);
    reset = 1'b1;
    set_lv(2);
    ld = 4'b1111;
    step(1);
    ld = 4'b0000;
    en = 4'b0101;
    up = 4'b0001;
    step(3);
    chk("ind_ch0", int'(q2[7:0]), {6'd5, 2'd0});
    chk("ind_ch1", int'(q2[15:8]), {6'd2, 2'd1});
    chk("ind_ch2", int'(q2[23:16]), {6'd63, 2'd2});
    chk("ind_ch3", int'(q2[31:24]), {6'd2, 2'd3});
    repeat (400) begin
      en = 4'($urandom);
      up = 4'($urandom);
      os = 4'($urandom) & 4'($urandom);
      ld = 4'($urandom) & 4'($urandom) & 4'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      for (int c = 0; c < 4; c++) lv[c] = 6'($urandom);
      step(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
